uart_word_packer: RTL and testbench

Parametrised byte-to-word assembler between the UART receiver and the loader/CPU memory path. It collects BYTES_PER_WORD received bytes in a selectable byte order and buffers completed words in a small FIFO with a valid/ready output handshake. It counts accepted words and discards stale partial words after an inter-byte timeout. It reports overrun and timeout errors as sticky flags.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_word_packer.sv | 172 +++++++++++++++++
 tb/tb_uart_word_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte-to-word packer.
package uart_pkg;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } asm_state_e;

    // Bit width needed to index 'value' entries, never less than 1.
    function automatic int clog2_safe(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Byte lane written by the idx-th received byte of a word.
    function automatic int lane_index(input int idx, input int bpw, input bit little_endian);
        return little_endian ? idx : (bpw - 1 - idx);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [clog2_safe(DEPTH):0]   count
);

    localparam int AW = clog2_safe(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == '0);
    assign pop_ok_s  = pop && !empty_s;
    assign push_ok_s = push && (!full_s || pop_ok_s);

    // Storage array; contents are masked on the output while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = empty_s ? '0 : mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;

endmodule

// File: rtl/uart_word_packer.sv
// Assembles UART bytes into words, buffers them in a FIFO, counts pushes and
// tracks sticky overrun/timeout errors.
module uart_word_packer
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter bit LITTLE_ENDIAN  = 1'b1,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [WORD_WIDTH-1:0]  word_data,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   partial,
    output logic                   overrun,
    output logic                   timeout_err,
    input  logic                   clear_err
);

    localparam int BPW        = WORD_WIDTH / 8;
    localparam int IDX_W      = clog2_safe(BPW);
    localparam int FAW        = clog2_safe(FIFO_DEPTH);
    localparam int TW         = clog2_safe(TIMEOUT_CYCLES + 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW:0]      TO_LIM   = (TW+1)'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

    asm_state_e            state_r, state_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic [WORD_WIDTH-1:0] asm_r, asm_nxt_s;
    logic [WORD_WIDTH-1:0] with_byte_s;
    logic [TW-1:0]         timer_r;
    logic [COUNT_WIDTH-1:0] word_count_r;
    logic                  overrun_r;
    logic                  timeout_err_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  expire_s;
    logic                  drop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FAW:0]          fifo_count_s;
    int                    lane_sel_s;

    assign lane_sel_s = lane_index(int'(idx_r), BPW, LITTLE_ENDIAN);
    assign pop_s      = word_ready && (fifo_count_s != '0);
    assign drop_s     = push_s && fifo_full_s && !pop_s;
    assign expire_s   = TIMEOUT_EN && (state_r == S_COLLECT) && !byte_valid &&
                        (({1'b0, timer_r} + (TW+1)'(1)) == TO_LIM);

    // Current word with the incoming byte merged in; the first byte starts from zero.
    always_comb begin
        with_byte_s = (idx_r == '0) ? '0 : asm_r;
        for (int l = 0; l < BPW; l++) begin
            if (l == lane_sel_s) begin
                with_byte_s[l*8 +: 8] = byte_data;
            end else begin
                with_byte_s[l*8 +: 8] = with_byte_s[l*8 +: 8];
            end
        end
    end

    // Assembler next state: collect bytes, push on the last one, abandon on timeout.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        asm_nxt_s   = asm_r;
        push_s      = 1'b0;
        case (state_r)
            S_IDLE, S_COLLECT: begin
                if (byte_valid) begin
                    if (idx_r == IDX_LAST) begin
                        push_s      = 1'b1;
                        idx_nxt_s   = '0;
                        asm_nxt_s   = '0;
                        state_nxt_s = S_IDLE;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_W'(1);
                        asm_nxt_s   = with_byte_s;
                        state_nxt_s = S_COLLECT;
                    end
                end else if (expire_s) begin
                    idx_nxt_s   = '0;
                    asm_nxt_s   = '0;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                idx_nxt_s   = '0;
                asm_nxt_s   = '0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Assembler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
            asm_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            asm_r   <= asm_nxt_s;
        end
    end

    // Inter-byte idle timer; only runs while a word is partially collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (byte_valid || (state_r == S_IDLE) || expire_s) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // Push counter and sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_r  <= '0;
            overrun_r     <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (push_s && !drop_s) begin
                word_count_r <= word_count_r + COUNT_WIDTH'(1);
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clear_err) begin
                overrun_r <= 1'b0;
            end
            if (expire_s) begin
                timeout_err_r <= 1'b1;
            end else if (clear_err) begin
                timeout_err_r <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (with_byte_s),
        .pop       (pop_s),
        .pop_data  (word_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign word_valid  = !fifo_empty_s;
    assign word_count  = word_count_r;
    assign partial     = (state_r == S_COLLECT);
    assign overrun     = overrun_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench: three packer configurations share one stimulus stream.
module tb_uart_word_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       word_ready = 1'b0;
    logic       clear_err = 1'b0;

    // a: 16-bit LE, depth 4, timeout 10
    logic        a_valid, a_partial, a_ovr, a_tmo;
    logic [15:0] a_data, a_count;
    // b: 32-bit BE
    logic        b_valid, b_partial, b_ovr, b_tmo;
    logic [31:0] b_data;
    logic [15:0] b_count;
    // c: 4-bit word counter
    logic        c_valid, c_partial, c_ovr, c_tmo;
    logic [15:0] c_data;
    logic [3:0]  c_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_word_packer #(.WORD_WIDTH(16), .LITTLE_ENDIAN(1'b1), .FIFO_DEPTH(4),
                       .TIMEOUT_CYCLES(10), .COUNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .word_valid(a_valid), .word_ready(word_ready), .word_data(a_data),
        .word_count(a_count), .partial(a_partial), .overrun(a_ovr),
        .timeout_err(a_tmo), .clear_err(clear_err));

    uart_word_packer #(.WORD_WIDTH(32), .LITTLE_ENDIAN(1'b0), .FIFO_DEPTH(4),
                       .TIMEOUT_CYCLES(0), .COUNT_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .word_valid(b_valid), .word_ready(word_ready), .word_data(b_data),
        .word_count(b_count), .partial(b_partial), .overrun(b_ovr),
        .timeout_err(b_tmo), .clear_err(clear_err));

    uart_word_packer #(.WORD_WIDTH(16), .LITTLE_ENDIAN(1'b1), .FIFO_DEPTH(4),
                       .TIMEOUT_CYCLES(0), .COUNT_WIDTH(4)) u_c (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .word_valid(c_valid), .word_ready(word_ready), .word_data(c_data),
        .word_count(c_count), .partial(c_partial), .overrun(c_ovr),
        .timeout_err(c_tmo), .clear_err(clear_err));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_word16(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        logic [15:0] w;

        // 1: reset values and basic LE word
        tick();
        do_reset();
        check_eq("rst_valid", a_valid, 1'b0);
        check_eq("rst_data", a_data, 16'h0000);
        check_eq("rst_count", a_count, 16'h0000);
        check_eq("rst_partial", a_partial, 1'b0);
        check_eq("rst_ovr", a_ovr, 1'b0);
        check_eq("rst_tmo", a_tmo, 1'b0);
        word_ready = 1'b1;
        send_byte(8'h34);
        check_eq("t1_partial_mid", a_partial, 1'b1);
        check_eq("t1_valid_mid", a_valid, 1'b0);
        send_byte(8'h12);
        check_eq("t1_valid", a_valid, 1'b1);
        check_eq("t1_data", a_data, 16'h1234);
        check_eq("t1_count", a_count, 16'h0001);
        check_eq("t1_partial_end", a_partial, 1'b0);
        tick();
        check_eq("t1_valid_drop", a_valid, 1'b0);

        // 2: 32-bit big-endian
        do_reset();
        word_ready = 1'b0;
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        check_eq("t2_partial", b_partial, 1'b1);
        check_eq("t2_valid_early", b_valid, 1'b0);
        send_byte(8'hEF);
        check_eq("t2_valid", b_valid, 1'b1);
        check_eq("t2_data", b_data, 32'hDEADBEEF);

        // 3: overrun with full FIFO, ordered drain, clear
        do_reset();
        word_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            w = 16'(k);
            send_word16(w);
        end
        check_eq("t3_count", a_count, 16'd4);
        check_eq("t3_ovr", a_ovr, 1'b1);
        word_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("t3_drain", a_data, 64'(k));
            tick();
        end
        check_eq("t3_empty", a_valid, 1'b0);
        word_ready = 1'b0;
        check_eq("t3_ovr_held", a_ovr, 1'b1);
        pulse_clear();
        check_eq("t3_ovr_clr", a_ovr, 1'b0);

        // 4: last byte of 5th word coincides with a pop from a full FIFO
        do_reset();
        word_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w = 16'(k);
            send_word16(w);
        end
        send_byte(8'h05);
        word_ready = 1'b1;
        send_byte(8'h00);
        check_eq("t4_ovr", a_ovr, 1'b0);
        check_eq("t4_count", a_count, 16'd5);
        for (int k = 2; k <= 5; k++) begin
            check_eq("t4_drain", a_data, 64'(k));
            tick();
        end
        check_eq("t4_empty", a_valid, 1'b0);

        // 5: inter-byte timeout
        do_reset();
        word_ready = 1'b0;
        send_byte(8'hAA);
        for (int k = 0; k < 9; k++) tick();
        check_eq("t5_pre_tmo", a_tmo, 1'b0);
        check_eq("t5_pre_partial", a_partial, 1'b1);
        tick();
        check_eq("t5_tmo", a_tmo, 1'b1);
        check_eq("t5_partial", a_partial, 1'b0);
        check_eq("t5_novalid", a_valid, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        check_eq("t5_data", a_data, 16'h0201);
        check_eq("t5_tmo_sticky", a_tmo, 1'b1);
        word_ready = 1'b1;
        pulse_clear();
        word_ready = 1'b0;
        check_eq("t5_tmo_clr", a_tmo, 1'b0);
        send_byte(8'h11);
        for (int k = 0; k < 9; k++) tick();
        send_byte(8'h22);
        check_eq("t5_expiry_tmo", a_tmo, 1'b0);
        check_eq("t5_expiry_data", a_data, 16'h2211);

        // 6: reset mid-word with queued words, then counter wrap
        do_reset();
        word_ready = 1'b0;
        send_word16(16'h0A0B);
        send_word16(16'h0C0D);
        send_byte(8'h77);
        do_reset();
        check_eq("t6_valid", a_valid, 1'b0);
        check_eq("t6_data", a_data, 16'h0000);
        check_eq("t6_count", a_count, 16'h0000);
        check_eq("t6_partial", a_partial, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        check_eq("t6_word", a_data, 16'h6655);
        check_eq("t6_count1", a_count, 16'd1);
        do_reset();
        word_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            w = 16'(16'h0100 + k);
            send_word16(w);
        end
        check_eq("t6_wrap_c", c_count, 4'd1);
        check_eq("t6_wrap_a", a_count, 16'd17);
        check_eq("t6_last_c", c_data, 16'h0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
